// File: rtl/mem_1r1w_masked_port_ctrl.sv
// Requester-side controller for a 1R1W masked SRAM with 1-cycle read latency.
// Turns valid/ready read and write requests into R0/W0 strobes and returns read data through a skid FIFO.
module mem_1r1w_masked_port_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 64,
    parameter int MASK_GRAN  = 8,
    parameter int SKID_DEPTH = 2,
    localparam int MASK_WIDTH = DATA_WIDTH / MASK_GRAN
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [MASK_WIDTH-1:0] wr_mask,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0] R0_addr,
    output logic                  R0_en,
    output logic                  R0_clk,
    input  logic [DATA_WIDTH-1:0] R0_data,
    output logic [ADDR_WIDTH-1:0] W0_addr,
    output logic                  W0_en,
    output logic                  W0_clk,
    output logic [DATA_WIDTH-1:0] W0_data,
    output logic [MASK_WIDTH-1:0] W0_mask
);

    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);

    logic                  r_active;
    logic                  r_inflight;
    logic [PTR_W-1:0]      r_headPtr;
    logic [PTR_W-1:0]      r_tailPtr;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_fifo [SKID_DEPTH];

    logic                  w_wrFire;
    logic                  w_rdFire;
    logic                  w_collide;
    logic                  w_credit;
    logic                  w_fifoEmpty;
    logic                  w_push;
    logic                  w_pop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(SKID_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign R0_clk = clock;
    assign W0_clk = clock;

    assign wr_ready = r_active;
    assign w_wrFire = wr_valid & wr_ready;
    assign W0_en    = w_wrFire;
    assign W0_addr  = wr_addr;
    assign W0_data  = wr_data;
    assign W0_mask  = wr_mask;

    // A read may only issue when a buffer slot is guaranteed for its data next cycle.
    assign w_collide = wr_valid & rd_valid & (rd_addr == wr_addr);
    assign w_credit  = ({1'b0, r_count} + (CNT_W + 1)'(r_inflight)) < (CNT_W + 1)'(SKID_DEPTH);
    assign rd_ready  = r_active & ~w_collide & w_credit;
    assign w_rdFire  = rd_valid & rd_ready;
    assign R0_en     = w_rdFire;
    assign R0_addr   = rd_addr;

    assign w_fifoEmpty = (r_count == '0);
    assign rsp_valid   = r_inflight | ~w_fifoEmpty;
    assign rsp_data    = w_fifoEmpty ? R0_data : r_fifo[r_headPtr];
    assign w_pop       = ~w_fifoEmpty & rsp_ready;
    assign w_push      = r_inflight & ~(w_fifoEmpty & rsp_ready);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_active   <= 1'b0;
            r_inflight <= 1'b0;
            r_headPtr  <= '0;
            r_tailPtr  <= '0;
            r_count    <= '0;
        end else begin
            r_active   <= 1'b1;
            r_inflight <= w_rdFire;
            if (w_push) begin
                r_tailPtr <= nextPtr(r_tailPtr);
            end
            if (w_pop) begin
                r_headPtr <= nextPtr(r_headPtr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_tailPtr] <= R0_data;
        end
    end

    assert property (@(posedge clock) disable iff (!reset_n)
        !(w_push && !w_pop && (r_count == CNT_W'(SKID_DEPTH))));

endmodule

// File: tb/tb_mem_1r1w_masked_port_ctrl.sv
// Self-checking bench for mem_1r1w_masked_port_ctrl: behavioural SRAM, reference memory and response scoreboard.
// Inputs change 1ns after the rising edge; everything is observed on the falling edge.
module tb_mem_1r1w_masked_port_ctrl;

    localparam int AW = 6;
    localparam int DW = 64;
    localparam int MW = 8;

    logic          clock;
    logic          reset_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [MW-1:0] wr_mask;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] R0_addr;
    logic          R0_en;
    logic          R0_clk;
    logic [DW-1:0] R0_data;
    logic [AW-1:0] W0_addr;
    logic          W0_en;
    logic          W0_clk;
    logic [DW-1:0] W0_data;
    logic [MW-1:0] W0_mask;

    logic [DW-1:0] tbMem  [2**AW];
    logic [DW-1:0] refMem [2**AW];
    logic [DW-1:0] expQ   [$];

    int checkCount = 0;
    int failCount  = 0;

    mem_1r1w_masked_port_ctrl dut (
        .clock(clock), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_mask(wr_mask),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .R0_addr(R0_addr), .R0_en(R0_en), .R0_clk(R0_clk), .R0_data(R0_data),
        .W0_addr(W0_addr), .W0_en(W0_en), .W0_clk(W0_clk),
        .W0_data(W0_data), .W0_mask(W0_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural SRAM macro: masked write, registered read with one cycle of latency.
    always @(posedge clock) begin
        if (W0_en) begin
            for (int l = 0; l < MW; l++) begin
                if (W0_mask[l]) tbMem[W0_addr][l*8 +: 8] <= W0_data[l*8 +: 8];
            end
        end
        if (R0_en) R0_data <= tbMem[R0_addr];
    end

    task automatic checkOutput(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [DW-1:0] patData(input int i);
        return 64'hC0DE_0000_0000_0000 | (64'(i) * 64'h0000_0101_0101_0101);
    endfunction

    function automatic logic [DW-1:0] mergeLanes(input logic [DW-1:0] oldVal, input logic [DW-1:0] newVal,
                                                 input logic [MW-1:0] mask);
        logic [DW-1:0] res;
        res = oldVal;
        for (int l = 0; l < MW; l++) begin
            if (mask[l]) res[l*8 +: 8] = newVal[l*8 +: 8];
        end
        return res;
    endfunction

    // Scoreboard: writes update the reference first, so a read wrongly let through in
    // the same cycle as a colliding write would return stale data and be caught here.
    always @(negedge clock) begin
        if (reset_n) begin
            if (wr_valid && wr_ready) refMem[wr_addr] = mergeLanes(refMem[wr_addr], wr_data, wr_mask);
            if (rd_valid && rd_ready) expQ.push_back(refMem[rd_addr]);
            if (rsp_valid && rsp_ready) begin
                if (expQ.size() == 0) checkOutput("unexpected rsp", {63'd0, rsp_valid}, 64'd0);
                else checkOutput("rsp order/data", rsp_data, expQ.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                 input logic [MW-1:0] wm, input logic rv, input logic [AW-1:0] ra);
        wr_valid = wv; wr_addr = wa; wr_data = wd; wr_mask = wm;
        rd_valid = rv; rd_addr = ra;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    localparam logic [DW-1:0] FULL_DATA = 64'h0123456789ABCDEF;
    localparam logic [DW-1:0] COLL_DATA = 64'hDEAD_BEEF_CAFE_F00D;

    initial begin : stimulus
        int accepted;
        int stalls;
        int gaps;
        int staleRsp;
        int notReady;
        for (int a = 0; a < 2**AW; a++) begin
            tbMem[a]  = '0;
            refMem[a] = '0;
        end
        R0_data   = '0;
        rsp_ready = 1'b1;
        reset_n   = 1'b0;
        applyStimulus(1'b1, 6'd1, 64'd1, 8'hFF, 1'b1, 6'd2);

        // Everything handshake-related must stay low while reset is held, even with requests pending.
        @(negedge clock);
        checkOutput("reset wr_ready", {63'd0, wr_ready}, 64'd0);
        checkOutput("reset rd_ready", {63'd0, rd_ready}, 64'd0);
        checkOutput("reset rsp_valid", {63'd0, rsp_valid}, 64'd0);
        checkOutput("reset R0_en", {63'd0, R0_en}, 64'd0);
        checkOutput("reset W0_en", {63'd0, W0_en}, 64'd0);
        nextCycle();
        reset_n = 1'b1;
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
        nextCycle();
        @(negedge clock);
        checkOutput("post-reset wr_ready", {63'd0, wr_ready}, 64'd1);
        checkOutput("post-reset rd_ready", {63'd0, rd_ready}, 64'd1);
        nextCycle();

        // Full-width write then a read of the same word on the following cycle.
        applyStimulus(1'b1, 6'd5, FULL_DATA, 8'hFF, 1'b0, '0);
        @(negedge clock);
        checkOutput("W0_en on write", {63'd0, W0_en}, 64'd1);
        checkOutput("W0 addr/mask", {50'd0, W0_addr, W0_mask}, {50'd0, 6'd5, 8'hFF});
        checkOutput("W0_data", W0_data, FULL_DATA);
        nextCycle();
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 6'd5);
        @(negedge clock);
        checkOutput("R0_en on read", {63'd0, R0_en}, 64'd1);
        nextCycle();
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
        @(negedge clock);
        checkOutput("read latency rsp_valid", {63'd0, rsp_valid}, 64'd1);
        checkOutput("full write readback", rsp_data, FULL_DATA);
        nextCycle();

        // Lower four lanes overwritten, upper lanes keep the old bytes.
        applyStimulus(1'b1, 6'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b0, '0);
        nextCycle();
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 6'd5);
        nextCycle();
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
        @(negedge clock);
        checkOutput("masked merge", rsp_data, 64'h01234567FFFFFFFF);
        nextCycle();

        // Zero-mask write still strobes the macro but leaves the word unchanged.
        applyStimulus(1'b1, 6'd5, 64'h1111_2222_3333_4444, 8'h00, 1'b0, '0);
        @(negedge clock);
        checkOutput("zero-mask W0_en", {63'd0, W0_en}, 64'd1);
        nextCycle();
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 6'd5);
        nextCycle();
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
        @(negedge clock);
        checkOutput("zero-mask unchanged", rsp_data, 64'h01234567FFFFFFFF);
        nextCycle();

        // Same-address write and read: the read waits one cycle and sees the new word.
        applyStimulus(1'b1, 6'd9, COLL_DATA, 8'hFF, 1'b1, 6'd9);
        @(negedge clock);
        checkOutput("collide rd_ready", {63'd0, rd_ready}, 64'd0);
        nextCycle();
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 6'd9);
        @(negedge clock);
        checkOutput("post-collide rd_ready", {63'd0, rd_ready}, 64'd1);
        nextCycle();
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
        @(negedge clock);
        checkOutput("collide rsp_valid", {63'd0, rsp_valid}, 64'd1);
        checkOutput("collide new data", rsp_data, COLL_DATA);
        nextCycle();

        // Preload words 0..47 with a known pattern.
        for (int i = 0; i < 48; i++) begin
            applyStimulus(1'b1, 6'(i), patData(i), 8'hFF, 1'b0, '0);
            nextCycle();
        end

        // With responses blocked only SKID_DEPTH reads may be taken.
        rsp_ready = 1'b0;
        accepted  = 0;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b0, '0, '0, '0, 1'b1, 6'(accepted));
            @(negedge clock);
            if (rd_ready) accepted++;
            nextCycle();
        end
        checkOutput("backpressure accepted", 64'(accepted), 64'd2);
        rsp_ready = 1'b1;
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 6'd2);
        @(negedge clock);
        checkOutput("bp first rsp", rsp_data, patData(0));
        checkOutput("bp full rd_ready", {63'd0, rd_ready}, 64'd0);
        nextCycle();
        @(negedge clock);
        checkOutput("bp second rsp", rsp_data, patData(1));
        checkOutput("bp addr2 accepted", {63'd0, rd_ready}, 64'd1);
        nextCycle();
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
        @(negedge clock);
        checkOutput("bp third rsp", rsp_data, patData(2));
        nextCycle();

        // Back-to-back reads with an always-ready consumer: no stalls, no response gaps.
        stalls = 0;
        gaps   = 0;
        for (int i = 0; i <= 48; i++) begin
            applyStimulus(1'b0, '0, '0, '0, (i < 48), 6'(i % 48));
            @(negedge clock);
            if (i < 48 && !rd_ready) stalls++;
            if (i > 0 && !rsp_valid) gaps++;
            nextCycle();
        end
        checkOutput("stream stalls", 64'(stalls), 64'd0);
        checkOutput("stream gaps", 64'(gaps), 64'd0);

        // Reset with one response buffered and one in flight drops both.
        rsp_ready = 1'b0;
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 6'd3);
        nextCycle();
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 6'd4);
        nextCycle();
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
        checkOutput("pre-reset rsp_valid", {63'd0, rsp_valid}, 64'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("mid-reset rsp_valid", {63'd0, rsp_valid}, 64'd0);
        expQ.delete();
        nextCycle();
        nextCycle();
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        nextCycle();
        staleRsp = 0;
        notReady = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (rsp_valid) staleRsp++;
            if (!rd_ready) notReady++;
            nextCycle();
        end
        checkOutput("stale responses", 64'(staleRsp), 64'd0);
        checkOutput("post-reset rd_ready", 64'(notReady), 64'd0);
        checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
